// File: rtl/mem_bus_arbiter_pkg.sv
// Shared types and defaults for the instruction/data memory bus arbiter.
package mem_bus_arbiter_pkg;

  localparam int DEFAULT_ADDR_W         = 32;
  localparam int DEFAULT_DATA_W         = 32;
  localparam int DEFAULT_TIMEOUT_CYCLES = 255;

  typedef enum logic [1:0] {
    IDLE,
    BUSY_I,
    BUSY_D
  } ArbState;

  typedef enum logic {
    GRANT_INSN,
    GRANT_DATA
  } GrantId;

endpackage

// File: rtl/mem_arb_watchdog.sv
// Busy-cycle watchdog for mem_bus_arbiter; compiled only when MEM_ARB_TIMEOUT_EN is defined.
`ifdef MEM_ARB_TIMEOUT_EN
module mem_arb_watchdog
  import mem_bus_arbiter_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  input  logic busy,
  input  logic memAck,
  output logic expired
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] count;

  assign expired = busy && (count == CNT_W'(TIMEOUT_CYCLES));

  // Counts only unacknowledged busy cycles; parks at the limit until the next grant.
  always_ff @(posedge clk) begin
    if (rst || start) begin
      count <= '0;
    end else if (busy && !memAck && !expired) begin
      count <= count + CNT_W'(1);
    end
  end

endmodule
`endif

// File: rtl/mem_bus_arbiter.sv
// Alternating-priority arbiter sharing one memory between fetch and load/store paths.
// Optional watchdog with forced completion: define MEM_ARB_TIMEOUT_EN.
module mem_bus_arbiter
  import mem_bus_arbiter_pkg::*;
#(
  parameter int ADDR_W         = DEFAULT_ADDR_W,
  parameter int DATA_W         = DEFAULT_DATA_W,
  parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              iReq,
  input  logic [ADDR_W-1:0] iAddr,
  output logic              iAck,
  output logic [DATA_W-1:0] iRdData,
  input  logic              dReq,
  input  logic              dWe,
  input  logic [ADDR_W-1:0] dAddr,
  input  logic [DATA_W-1:0] dWrData,
  output logic              dAck,
  output logic [DATA_W-1:0] dRdData,
  output logic              memReq,
  output logic              memWe,
  output logic [ADDR_W-1:0] memAddr,
  output logic [DATA_W-1:0] memWrData,
  input  logic              memAck,
  input  logic [DATA_W-1:0] memRdData,
  output logic              busy,
  output logic              timeoutErr
);

  ArbState state, nextState;
  GrantId  lastGrant;
  logic    grantData, grantInsn, startGrant;
  logic    expired, done, forcedDone;

  // On a tie, data wins unless it was the last one served.
  assign grantData  = dReq && (!iReq || lastGrant == GRANT_INSN);
  assign grantInsn  = iReq && !grantData;
  assign startGrant = (state == IDLE) && (iReq || dReq);
  assign busy       = (state != IDLE);
  assign done       = busy && (memAck || expired);
  assign forcedDone = expired && !memAck;

`ifdef MEM_ARB_TIMEOUT_EN
  mem_arb_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk    (clk),
    .rst    (rst),
    .start  (startGrant),
    .busy   (busy),
    .memAck (memAck),
    .expired(expired)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      timeoutErr <= 1'b0;
    end else if (forcedDone) begin
      timeoutErr <= 1'b1;
    end
  end
`else
  // Keeps the timeout parameter referenced in builds without a watchdog.
  assign expired    = 1'b0 && (TIMEOUT_CYCLES > 0);
  assign timeoutErr = 1'b0;
`endif

  assign iAck    = (state == BUSY_I) && done;
  assign dAck    = (state == BUSY_D) && done;
  assign iRdData = forcedDone ? '0 : memRdData;
  assign dRdData = forcedDone ? '0 : memRdData;

  always_comb begin
    // NOTE: assign the default first so every path drives nextState; otherwise a latch is inferred.
    nextState = state;
    unique case (state)
      IDLE: begin
        if (grantData) begin
          nextState = BUSY_D;
        end else if (grantInsn) begin
          nextState = BUSY_I;
        end
      end
      BUSY_I, BUSY_D: begin
        if (done) begin
          nextState = IDLE;
        end
      end
      default: nextState = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= nextState;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      memReq    <= 1'b0;
      memWe     <= 1'b0;
      memAddr   <= '0;
      memWrData <= '0;
      lastGrant <= GRANT_INSN;
    end else if (state == IDLE) begin
      if (grantData) begin
        memReq    <= 1'b1;
        memWe     <= dWe;
        memAddr   <= dAddr;
        memWrData <= dWrData;
      end else if (grantInsn) begin
        memReq  <= 1'b1;
        memWe   <= 1'b0;
        memAddr <= iAddr;
      end
    end else if (done) begin
      memReq    <= 1'b0;
      lastGrant <= (state == BUSY_D) ? GRANT_DATA : GRANT_INSN;
    end
  end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Self-checking bench for mem_bus_arbiter: directed vector table, hand sequences and
// randomized traffic against a transaction-level reference model.
module tb_mem_bus_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TO = 4;
`ifdef MEM_ARB_TIMEOUT_EN
  localparam bit TIMEOUT_ON = 1'b1;
`else
  localparam bit TIMEOUT_ON = 1'b0;
`endif

  logic          clk, rst;
  logic          iReq, iAck, dReq, dWe, dAck;
  logic [AW-1:0] iAddr, dAddr, memAddr;
  logic [DW-1:0] iRdData, dWrData, dRdData, memWrData, memRdData;
  logic          memReq, memWe, memAck, busy, timeoutErr;

  int nCompared   = 0;
  int nMismatched = 0;

  mem_bus_arbiter #(
    .ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk), .rst(rst),
    .iReq(iReq), .iAddr(iAddr), .iAck(iAck), .iRdData(iRdData),
    .dReq(dReq), .dWe(dWe), .dAddr(dAddr), .dWrData(dWrData),
    .dAck(dAck), .dRdData(dRdData),
    .memReq(memReq), .memWe(memWe), .memAddr(memAddr), .memWrData(memWrData),
    .memAck(memAck), .memRdData(memRdData),
    .busy(busy), .timeoutErr(timeoutErr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    nCompared++;
    if (act !== exp) begin
      nMismatched++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct packed {
    logic          rst;
    logic          iReq;
    logic [AW-1:0] iAddr;
    logic          dReq;
    logic          dWe;
    logic [AW-1:0] dAddr;
    logic [DW-1:0] dWrData;
    logic          memAck;
    logic [DW-1:0] memRdData;
    logic          eIAck;
    logic          eDAck;
    logic          eBusy;
    logic          eMemReq;
    logic          chkMem;
    logic          eMemWe;
    logic [AW-1:0] eMemAddr;
    logic [DW-1:0] eMemWrData;
    logic          chkRd;
    logic [DW-1:0] eRd;
  } Vec;

  localparam int NVEC = 18;
  Vec vecs[NVEC];

  // Reference model state (transaction level).
  int            owner;      // 0 none, 1 fetch, 2 data
  bit            prevData;   // last completed transaction was a data access
  bit            mReq, mWe, mErr;
  logic [AW-1:0] mAddr;
  logic [DW-1:0] mWrData;
  int            mWait;
  bit            ackI, ackD;

  task automatic modelReset();
    owner = 0; prevData = 1'b0; mReq = 1'b0; mWe = 1'b0; mErr = 1'b0;
    mAddr = '0; mWrData = '0; mWait = 0;
  endtask

  task automatic clearInputs();
    iReq = 0; iAddr = '0; dReq = 0; dWe = 0; dAddr = '0; dWrData = '0;
    memAck = 0; memRdData = '0;
  endtask

  task automatic resetCycle();
    clearInputs();
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  initial begin
    //                rst I  iAddr  D  We dAddr   dWrData       ack rdData      iA dA bsy mRq chk mWe mAddr  mWrData       chkRd eRd
    vecs[0]  = '{1'b0, 0, 32'h0,   0, 0, 32'h0,   32'h0,        0, 32'h0,       0, 0, 0, 0, 1, 0, 32'h0,   32'h0,        0, 32'h0};
    vecs[1]  = '{1'b0, 1, 32'h40,  0, 0, 32'h0,   32'h0,        0, 32'h0,       0, 0, 0, 0, 1, 0, 32'h0,   32'h0,        0, 32'h0};
    vecs[2]  = '{1'b0, 1, 32'h40,  0, 0, 32'h0,   32'h0,        1, 32'h13,      1, 0, 1, 1, 1, 0, 32'h40,  32'h0,        1, 32'h13};
    vecs[3]  = '{1'b0, 1, 32'h44,  0, 0, 32'h0,   32'h0,        0, 32'h0,       0, 0, 0, 0, 0, 0, 32'h0,   32'h0,        0, 32'h0};
    vecs[4]  = '{1'b0, 1, 32'h44,  0, 0, 32'h0,   32'h0,        1, 32'h17,      1, 0, 1, 1, 1, 0, 32'h44,  32'h0,        1, 32'h17};
    vecs[5]  = '{1'b0, 0, 32'h0,   0, 0, 32'h0,   32'h0,        1, 32'h99,      0, 0, 0, 0, 0, 0, 32'h0,   32'h0,        0, 32'h0};
    vecs[6]  = '{1'b0, 0, 32'h0,   1, 1, 32'h100, 32'hDEADBEEF, 0, 32'h0,       0, 0, 0, 0, 0, 0, 32'h0,   32'h0,        0, 32'h0};
    vecs[7]  = '{1'b0, 0, 32'h0,   1, 1, 32'h100, 32'h12345678, 0, 32'h0,       0, 0, 1, 1, 1, 1, 32'h100, 32'hDEADBEEF, 0, 32'h0};
    vecs[8]  = '{1'b0, 0, 32'h0,   1, 1, 32'h104, 32'h12345678, 0, 32'h0,       0, 0, 1, 1, 1, 1, 32'h100, 32'hDEADBEEF, 0, 32'h0};
    vecs[9]  = '{1'b0, 0, 32'h0,   1, 1, 32'h100, 32'hDEADBEEF, 0, 32'h0,       0, 0, 1, 1, 1, 1, 32'h100, 32'hDEADBEEF, 0, 32'h0};
    vecs[10] = '{1'b0, 0, 32'h0,   1, 1, 32'h100, 32'hDEADBEEF, 1, 32'hAAAA,    0, 1, 1, 1, 1, 1, 32'h100, 32'hDEADBEEF, 0, 32'h0};
    vecs[11] = '{1'b0, 0, 32'h0,   0, 0, 32'h0,   32'h0,        0, 32'h0,       0, 0, 0, 0, 0, 0, 32'h0,   32'h0,        0, 32'h0};
    vecs[12] = '{1'b0, 0, 32'h0,   1, 0, 32'h200, 32'h5555,     0, 32'h0,       0, 0, 0, 0, 0, 0, 32'h0,   32'h0,        0, 32'h0};
    vecs[13] = '{1'b1, 0, 32'h0,   1, 0, 32'h200, 32'h5555,     0, 32'h0,       0, 0, 1, 1, 1, 0, 32'h200, 32'h5555,     0, 32'h0};
    vecs[14] = '{1'b0, 0, 32'h0,   0, 0, 32'h0,   32'h0,        1, 32'h77,      0, 0, 0, 0, 1, 0, 32'h0,   32'h0,        0, 32'h0};
    vecs[15] = '{1'b0, 1, 32'h300, 1, 0, 32'h304, 32'h0,        0, 32'h0,       0, 0, 0, 0, 1, 0, 32'h0,   32'h0,        0, 32'h0};
    vecs[16] = '{1'b0, 1, 32'h300, 1, 0, 32'h304, 32'h0,        1, 32'h55,      0, 1, 1, 1, 1, 0, 32'h304, 32'h0,        1, 32'h55};
    vecs[17] = '{1'b0, 0, 32'h0,   0, 0, 32'h0,   32'h0,        0, 32'h0,       0, 0, 0, 0, 0, 0, 32'h0,   32'h0,        0, 32'h0};

    // Directed table: each record is one clock cycle.
    clearInputs();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    for (int k = 0; k < NVEC; k++) begin
      rst = vecs[k].rst; iReq = vecs[k].iReq; iAddr = vecs[k].iAddr;
      dReq = vecs[k].dReq; dWe = vecs[k].dWe; dAddr = vecs[k].dAddr; dWrData = vecs[k].dWrData;
      memAck = vecs[k].memAck; memRdData = vecs[k].memRdData;
      @(negedge clk);
      check($sformatf("v%0d iAck", k), 64'(iAck), 64'(vecs[k].eIAck));
      check($sformatf("v%0d dAck", k), 64'(dAck), 64'(vecs[k].eDAck));
      check($sformatf("v%0d busy", k), 64'(busy), 64'(vecs[k].eBusy));
      check($sformatf("v%0d memReq", k), 64'(memReq), 64'(vecs[k].eMemReq));
      check($sformatf("v%0d timeoutErr", k), 64'(timeoutErr), 64'(0));
      if (vecs[k].chkMem) begin
        check($sformatf("v%0d memWe", k), 64'(memWe), 64'(vecs[k].eMemWe));
        check($sformatf("v%0d memAddr", k), 64'(memAddr), 64'(vecs[k].eMemAddr));
        check($sformatf("v%0d memWrData", k), 64'(memWrData), 64'(vecs[k].eMemWrData));
      end
      if (vecs[k].chkRd) begin
        if (vecs[k].eIAck) check($sformatf("v%0d iRdData", k), 64'(iRdData), 64'(vecs[k].eRd));
        else               check($sformatf("v%0d dRdData", k), 64'(dRdData), 64'(vecs[k].eRd));
      end
      @(posedge clk); #1;
    end

    // Both requesters held, zero-wait memory: grants alternate D, I, D, I.
    resetCycle();
    iReq = 1; dReq = 1; dWe = 0; iAddr = 32'h500; dAddr = 32'h600;
    memAck = 1; memRdData = 32'h1234;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      check($sformatf("alt%0d iAck", c), 64'(iAck), 64'((c % 4) == 3));
      check($sformatf("alt%0d dAck", c), 64'(dAck), 64'((c % 4) == 1));
      if ((c % 2) == 1)
        check($sformatf("alt%0d memAddr", c), 64'(memAddr), ((c % 4) == 1) ? 64'h600 : 64'h500);
      @(posedge clk); #1;
    end

`ifdef MEM_ARB_TIMEOUT_EN
    // Memory never answers: forced load completion with zero data after TO busy cycles.
    resetCycle();
    dWe = 0; dAddr = 32'h700; memAck = 0; memRdData = 32'hFFFFFFFF;
    for (int c = 0; c < 7; c++) begin
      dReq = (c <= 5);
      @(negedge clk);
      check($sformatf("to%0d dAck", c), 64'(dAck), 64'(c == 5));
      check($sformatf("to%0d busy", c), 64'(busy), 64'(c >= 1 && c <= 5));
      check($sformatf("to%0d timeoutErr", c), 64'(timeoutErr), 64'(c == 6));
      if (c == 5) check("to dRdData", 64'(dRdData), 64'(0));
      @(posedge clk); #1;
    end
    dReq = 1; memAck = 1;
    @(posedge clk); #1;
    @(negedge clk);
    check("to normal dAck", 64'(dAck), 64'(1));
    check("to sticky", 64'(timeoutErr), 64'(1));
    @(posedge clk); #1;
    resetCycle();
    @(negedge clk);
    check("to cleared", 64'(timeoutErr), 64'(0));
    @(posedge clk); #1;
`endif

    // Randomized traffic against the reference model.
    resetCycle();
    modelReset();
    ackI = 0; ackD = 0;
    for (int n = 0; n < 3000; n++) begin
      bit busyE, forced, doneE, eI, eD, pickData;
      rst = ($urandom_range(0, 99) == 0);
      memAck = ($urandom_range(0, 2) == 0);
      memRdData = $urandom;
      if (ackI) begin
        iReq = $urandom_range(0, 1);
        if (iReq) iAddr = $urandom;
      end else if (!iReq && $urandom_range(0, 3) == 0) begin
        iReq = 1; iAddr = $urandom;
      end
      if (ackD) begin
        dReq = $urandom_range(0, 1);
        if (dReq) begin dAddr = $urandom; dWe = $urandom_range(0, 1); dWrData = $urandom; end
      end else if (!dReq && $urandom_range(0, 3) == 0) begin
        dReq = 1; dAddr = $urandom; dWe = $urandom_range(0, 1); dWrData = $urandom;
      end

      @(negedge clk);
      busyE  = (owner != 0);
      forced = TIMEOUT_ON && busyE && !memAck && (mWait == TO);
      doneE  = busyE && (memAck || forced);
      eI     = (owner == 1) && doneE;
      eD     = (owner == 2) && doneE;
      check("rnd iAck", 64'(iAck), 64'(eI));
      check("rnd dAck", 64'(dAck), 64'(eD));
      check("rnd busy", 64'(busy), 64'(busyE));
      check("rnd memReq", 64'(memReq), 64'(mReq));
      check("rnd timeoutErr", 64'(timeoutErr), 64'(mErr));
      if (mReq) begin
        check("rnd memWe", 64'(memWe), 64'(mWe));
        check("rnd memAddr", 64'(memAddr), 64'(mAddr));
        check("rnd memWrData", 64'(memWrData), 64'(mWrData));
      end
      if (eI) check("rnd iRdData", 64'(iRdData), forced ? 64'(0) : 64'(memRdData));
      if (eD && !mWe) check("rnd dRdData", 64'(dRdData), forced ? 64'(0) : 64'(memRdData));

      if (rst) begin
        modelReset();
      end else if (owner == 0) begin
        if (iReq || dReq) begin
          pickData = dReq && !(iReq && prevData);
          owner = pickData ? 2 : 1;
          mReq  = 1'b1;
          mWe   = pickData ? dWe : 1'b0;
          mAddr = pickData ? dAddr : iAddr;
          if (pickData) mWrData = dWrData;
          mWait = 0;
        end
      end else if (doneE) begin
        prevData = (owner == 2);
        owner = 0;
        mReq = 1'b0;
        if (forced) mErr = 1'b1;
      end else begin
        mWait++;
      end
      ackI = eI;
      ackD = eD;
      @(posedge clk); #1;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
    $finish;
  end

endmodule
